sample_recorder: RTL and testbench

SAMPLE_RECORDER -- requirements
Module: sample_recorder

---
 rtl/sample_recorder.sv | 177 +++++++++++++++++
 tb/tb_sample_recorder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_recorder.sv
// ---------------------------------------------------------------------------
// sample_recorder
//
// Records a take of audio samples into an external sample RAM. A take starts
// on rec_start, captures one word per sample_tick while recording, and ends
// either when the RAM capacity latched at start (max_depth) is filled or on
// rec_stop. All outputs are registered; a write appears one cycle after the
// sample_tick that carried the sample.
//
// Optional feature (macro REC_THRESHOLD_EN): voice-activated trigger. The ARM
// state waits for a sample whose magnitude reaches THRESHOLD; that sample is
// written at address 0 and recording continues from there. Without the macro
// ARM always lasts exactly one cycle and THRESHOLD has no effect.
//
// Ports
//   clock        : single rising-edge clock
//   resetn       : asynchronous active-low reset
//   sample_tick  : one-cycle sample strobe (44.1 kHz)
//   sample_in    : signed sample, valid with sample_tick
//   rec_start    : one-cycle request to begin a take
//   rec_stop     : one-cycle request to end a take
//   max_depth    : RAM capacity in words, latched at rec_start
//   wr_address   : RAM write address
//   wr_data      : RAM write data
//   wren         : one-cycle RAM write enable
//   recording    : high in ARM and REC
//   done         : high in DONE
//   length       : words written in the current or last take
// ---------------------------------------------------------------------------
module sample_recorder #(
    parameter int                ADDR_W    = 15,
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] THRESHOLD = 16'd1024
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              sample_tick,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              rec_start,
    input  logic              rec_stop,
    input  logic [ADDR_W-1:0] max_depth,
    output logic [ADDR_W-1:0] wr_address,
    output logic [DATA_W-1:0] wr_data,
    output logic              wren,
    output logic              recording,
    output logic              done,
    output logic [ADDR_W-1:0] length
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_REC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] depth_reg, depth_next;
    logic [ADDR_W-1:0] length_reg, length_next;
    logic [ADDR_W-1:0] wr_address_reg, wr_address_next;
    logic [DATA_W-1:0] wr_data_reg, wr_data_next;
    logic              wren_reg, wren_next;
    logic              recording_reg, recording_next;
    logic              done_reg, done_next;

`ifdef REC_THRESHOLD_EN
    // Magnitude of the incoming sample; the most negative value has no
    // positive counterpart, so it saturates to the largest positive value.
    logic [DATA_W-1:0] magnitude;
    logic              trigger;

    always_comb begin
        magnitude = sample_in;
        if (sample_in[DATA_W-1]) begin
            if (sample_in == {1'b1, {(DATA_W-1){1'b0}}}) begin
                magnitude = {1'b0, {(DATA_W-1){1'b1}}};
            end else begin
                magnitude = -sample_in;
            end
        end
        trigger = sample_tick && (magnitude >= THRESHOLD);
    end
`else
    // THRESHOLD has no function in this build; fold it into a sink.
    logic unused_threshold;
    assign unused_threshold = ^THRESHOLD;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_next      = state_reg;
        depth_next      = depth_reg;
        length_next     = length_reg;
        wr_address_next = wr_address_reg;
        wr_data_next    = wr_data_reg;
        wren_next       = 1'b0;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                // Start beats a coincident stop here.
                if (rec_start) begin
                    length_next = '0;
                    depth_next  = max_depth;
                    state_next  = (max_depth == '0) ? ST_DONE : ST_ARM;
                end
            end
            ST_ARM: begin
                if (rec_stop) begin
                    state_next = ST_DONE;
                end else begin
`ifdef REC_THRESHOLD_EN
                    if (trigger) begin
                        wren_next       = 1'b1;
                        wr_address_next = '0;
                        wr_data_next    = sample_in;
                        length_next     = ADDR_ONE;
                        state_next      = (depth_reg == ADDR_ONE) ? ST_DONE : ST_REC;
                    end
`else
                    state_next = ST_REC;
`endif
                end
            end
            ST_REC: begin
                // Stop beats a coincident sample: that sample is dropped.
                if (rec_stop) begin
                    state_next = ST_DONE;
                end else if (sample_tick) begin
                    wren_next       = 1'b1;
                    wr_address_next = length_reg;
                    wr_data_next    = sample_in;
                    length_next     = length_reg + ADDR_ONE;
                    // Last free word: finish on the same edge as the write.
                    if (length_reg == depth_reg - ADDR_ONE) begin
                        state_next = ST_DONE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        recording_next = (state_next == ST_ARM) || (state_next == ST_REC);
        done_next      = (state_next == ST_DONE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= ST_IDLE;
            depth_reg      <= '0;
            length_reg     <= '0;
            wr_address_reg <= '0;
            wr_data_reg    <= '0;
            wren_reg       <= 1'b0;
            recording_reg  <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            depth_reg      <= depth_next;
            length_reg     <= length_next;
            wr_address_reg <= wr_address_next;
            wr_data_reg    <= wr_data_next;
            wren_reg       <= wren_next;
            recording_reg  <= recording_next;
            done_reg       <= done_next;
        end
    end

    assign wr_address = wr_address_reg;
    assign wr_data    = wr_data_reg;
    assign wren       = wren_reg;
    assign recording  = recording_reg;
    assign done       = done_reg;
    assign length     = length_reg;

endmodule

// File: tb/tb_sample_recorder.sv
// ---------------------------------------------------------------------------
// tb_sample_recorder
//
// Directed bench for sample_recorder. Inputs change on the falling edge, the
// DUT acts on the rising edge, outputs are read on the following falling edge.
// A monitor logs every write into queues that each scenario inspects.
// ---------------------------------------------------------------------------
module tb_sample_recorder;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic              sample_tick = 1'b0;
    logic [DATA_W-1:0] sample_in = '0;
    logic              rec_start = 1'b0;
    logic              rec_stop = 1'b0;
    logic [ADDR_W-1:0] max_depth = '0;
    logic [ADDR_W-1:0] wr_address;
    logic [DATA_W-1:0] wr_data;
    logic              wren;
    logic              recording;
    logic              done;
    logic [ADDR_W-1:0] length;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] addr_q[$];
    logic [DATA_W-1:0] data_q[$];

    sample_recorder #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .THRESHOLD(16'd1024)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .sample_tick(sample_tick),
        .sample_in  (sample_in),
        .rec_start  (rec_start),
        .rec_stop   (rec_stop),
        .max_depth  (max_depth),
        .wr_address (wr_address),
        .wr_data    (wr_data),
        .wren       (wren),
        .recording  (recording),
        .done       (done),
        .length     (length)
    );

    always #5 clock = ~clock;

    // One line per RAM write.
    always @(negedge clock) begin
        if (wren) begin
            addr_q.push_back(wr_address);
            data_q.push_back(wr_data);
            $display("[%0t] write addr=%0d data=%0d", $time, wr_address, $signed(wr_data));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Stimulus helpers; they always return just after a falling edge.
    task automatic start_take(input logic [ADDR_W-1:0] depth);
        rec_start = 1'b1;
        max_depth = depth;
        @(negedge clock);
        rec_start = 1'b0;
    endtask

    task automatic tick(input logic [DATA_W-1:0] s);
        sample_tick = 1'b1;
        sample_in   = s;
        @(negedge clock);
        sample_tick = 1'b0;
        @(negedge clock);
    endtask

    task automatic clear_log();
        addr_q.delete();
        data_q.delete();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b expected 0", wren); end
        checks++; if (recording !== 1'b0) begin errors++; $display("FAIL reset_recording: got %b expected 0", recording); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (length !== '0) begin errors++; $display("FAIL reset_length: got %0d expected 0", length); end
        checks++; if (wr_address !== '0) begin errors++; $display("FAIL reset_wr_address: got %0d expected 0", wr_address); end
        checks++; if (wr_data !== '0) begin errors++; $display("FAIL reset_wr_data: got %0d expected 0", wr_data); end
        resetn = 1'b1;
        @(negedge clock);
    endtask

`ifndef REC_THRESHOLD_EN
    // Depth 4, six samples 1..6: only the first four are written.
    task automatic test_fill_depth();
        clear_log();
        start_take(15'd4);
        checks++; if (recording !== 1'b1) begin errors++; $display("FAIL fill_arm_recording: got %b expected 1", recording); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL fill_arm_done: got %b expected 0", done); end
        @(negedge clock);
        for (int i = 1; i <= 6; i++) tick(DATA_W'(i));
        @(negedge clock);
        checks++; if (addr_q.size() !== 4) begin errors++; $display("FAIL fill_write_count: got %0d expected 4", addr_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (addr_q[i] !== ADDR_W'(i)) begin errors++; $display("FAIL fill_addr%0d: got %0d expected %0d", i, addr_q[i], i); end
            checks++; if (data_q[i] !== DATA_W'(i + 1)) begin errors++; $display("FAIL fill_data%0d: got %0d expected %0d", i, data_q[i], i + 1); end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL fill_done: got %b expected 1", done); end
        checks++; if (recording !== 1'b0) begin errors++; $display("FAIL fill_recording: got %b expected 0", recording); end
        checks++; if (length !== 15'd4) begin errors++; $display("FAIL fill_length: got %0d expected 4", length); end
        checks++; if (wr_address !== 15'd3) begin errors++; $display("FAIL fill_hold_addr: got %0d expected 3", wr_address); end
        checks++; if (wr_data !== 16'd4) begin errors++; $display("FAIL fill_hold_data: got %0d expected 4", wr_data); end
    endtask

    // Stop coincident with the fourth sample: that sample is dropped.
    task automatic test_stop_wins();
        clear_log();
        start_take(15'd100);
        @(negedge clock);
        tick(16'd10);
        tick(16'd20);
        tick(16'd30);
        sample_tick = 1'b1;
        sample_in   = 16'd40;
        rec_stop    = 1'b1;
        @(negedge clock);
        sample_tick = 1'b0;
        rec_stop    = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (addr_q.size() !== 3) begin errors++; $display("FAIL stop_write_count: got %0d expected 3", addr_q.size()); end
        checks++; if (data_q[2] !== 16'd30) begin errors++; $display("FAIL stop_last_data: got %0d expected 30", data_q[2]); end
        checks++; if (length !== 15'd3) begin errors++; $display("FAIL stop_length: got %0d expected 3", length); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL stop_done: got %b expected 1", done); end
    endtask

    // max_depth=0 finishes immediately with nothing written.
    task automatic test_zero_depth();
        clear_log();
        start_take(15'd0);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", done); end
        checks++; if (length !== 15'd0) begin errors++; $display("FAIL zero_length: got %0d expected 0", length); end
        checks++; if (recording !== 1'b0) begin errors++; $display("FAIL zero_recording: got %b expected 0", recording); end
        tick(16'd5);
        checks++; if (addr_q.size() !== 0) begin errors++; $display("FAIL zero_no_write: got %0d writes expected 0", addr_q.size()); end
    endtask

    // Stop while armed, tick while armed, start while recording.
    task automatic test_arm_and_ignore();
        clear_log();
        start_take(15'd5);
        rec_stop    = 1'b1;
        sample_tick = 1'b1;
        sample_in   = 16'd99;
        @(negedge clock);
        rec_stop    = 1'b0;
        sample_tick = 1'b0;
        @(negedge clock);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL armstop_done: got %b expected 1", done); end
        checks++; if (length !== 15'd0) begin errors++; $display("FAIL armstop_length: got %0d expected 0", length); end
        checks++; if (addr_q.size() !== 0) begin errors++; $display("FAIL armstop_no_write: got %0d writes expected 0", addr_q.size()); end

        start_take(15'd5);
        tick(16'd77);          // lands in ARM: not written
        tick(16'd88);
        start_take(15'd1);     // ignored while recording
        tick(16'd89);
        @(negedge clock);
        checks++; if (addr_q.size() !== 2) begin errors++; $display("FAIL ignore_write_count: got %0d expected 2", addr_q.size()); end
        checks++; if (data_q[0] !== 16'd88) begin errors++; $display("FAIL armtick_data: got %0d expected 88", data_q[0]); end
        checks++; if (addr_q[1] !== 15'd1) begin errors++; $display("FAIL ignore_start_addr: got %0d expected 1", addr_q[1]); end
        checks++; if (length !== 15'd2) begin errors++; $display("FAIL ignore_start_length: got %0d expected 2", length); end
        checks++; if (recording !== 1'b1) begin errors++; $display("FAIL ignore_start_recording: got %b expected 1", recording); end
        rec_stop = 1'b1;
        @(negedge clock);
        rec_stop = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rec_stop_done: got %b expected 1", done); end
    endtask

    // DONE with length 4, then restart (with a coincident stop) at depth 2.
    task automatic test_restart();
        clear_log();
        start_take(15'd4);
        @(negedge clock);
        for (int i = 0; i < 4; i++) tick(DATA_W'(16'h100 + i));
        checks++; if (length !== 15'd4) begin errors++; $display("FAIL restart_prev_length: got %0d expected 4", length); end
        clear_log();
        rec_stop = 1'b1;
        start_take(15'd2);
        rec_stop = 1'b0;
        checks++; if (length !== 15'd0) begin errors++; $display("FAIL restart_cleared: got %0d expected 0", length); end
        checks++; if (recording !== 1'b1) begin errors++; $display("FAIL restart_start_wins: got %b expected 1", recording); end
        @(negedge clock);
        tick(16'h0aa);
        tick(16'h0bb);
        @(negedge clock);
        checks++; if (addr_q.size() !== 2) begin errors++; $display("FAIL restart_write_count: got %0d expected 2", addr_q.size()); end
        checks++; if (addr_q[0] !== 15'd0 || addr_q[1] !== 15'd1) begin errors++; $display("FAIL restart_addrs: got %0d,%0d expected 0,1", addr_q[0], addr_q[1]); end
        checks++; if (length !== 15'd2) begin errors++; $display("FAIL restart_length: got %0d expected 2", length); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL restart_done: got %b expected 1", done); end
    endtask

    // Reset after two writes aborts the take; a new take starts at address 0.
    task automatic test_reset_mid_take();
        clear_log();
        start_take(15'd10);
        @(negedge clock);
        tick(16'h111);
        tick(16'h222);
        #2 resetn = 1'b0;
        #1;
        checks++; if (wr_address !== '0 || wr_data !== '0) begin errors++; $display("FAIL midreset_wr: got addr=%0d data=%0d expected 0,0", wr_address, wr_data); end
        checks++; if (length !== '0 || recording !== 1'b0 || done !== 1'b0 || wren !== 1'b0) begin errors++; $display("FAIL midreset_status: got len=%0d rec=%b done=%b wren=%b expected all 0", length, recording, done, wren); end
        @(negedge clock);
        tick(16'h999);
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (addr_q.size() !== 2) begin errors++; $display("FAIL midreset_no_write: got %0d writes expected 2", addr_q.size()); end
        checks++; if (recording !== 1'b0) begin errors++; $display("FAIL midreset_idle: got recording=%b expected 0", recording); end
        clear_log();
        start_take(15'd3);
        @(negedge clock);
        tick(16'h333);
        checks++; if (addr_q.size() !== 1 || addr_q[0] !== 15'd0 || data_q[0] !== 16'h333) begin errors++; $display("FAIL midreset_restart: got n=%0d addr=%0d data=%0h expected 1,0,333", addr_q.size(), addr_q[0], data_q[0]); end
    endtask
`else
    // Voice trigger: only the -2000 sample starts the take.
    task automatic test_threshold();
        clear_log();
        start_take(15'd10);
        tick(16'd10);
        tick(-16'sd500);
        checks++; if (addr_q.size() !== 0) begin errors++; $display("FAIL thr_subthreshold: got %0d writes expected 0", addr_q.size()); end
        tick(-16'sd2000);
        tick(16'd7);
        @(negedge clock);
        checks++; if (addr_q.size() !== 2) begin errors++; $display("FAIL thr_write_count: got %0d expected 2", addr_q.size()); end
        checks++; if (addr_q[0] !== 15'd0 || data_q[0] !== 16'hf830) begin errors++; $display("FAIL thr_first: got addr=%0d data=%0h expected 0,f830", addr_q[0], data_q[0]); end
        checks++; if (addr_q[1] !== 15'd1 || data_q[1] !== 16'd7) begin errors++; $display("FAIL thr_second: got addr=%0d data=%0d expected 1,7", addr_q[1], data_q[1]); end
        checks++; if (length !== 15'd2) begin errors++; $display("FAIL thr_length: got %0d expected 2", length); end
    endtask
`endif

    initial begin
        test_reset();
`ifndef REC_THRESHOLD_EN
        test_fill_depth();
        test_stop_wins();
        test_zero_depth();
        test_arm_and_ignore();
        test_restart();
        test_reset_mid_take();
`else
        test_threshold();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
